// File: rtl/riscv_exec_ctrl.sv
// riscv_exec_ctrl: multi-cycle execute/memory/writeback sequencer for the RISC-V core.
// Holds one accepted instruction and drives writeback, PC redirect and a req/ack data port.
module riscv_exec_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PC_STEP     = 1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   rd_data,
    output logic              rd_we,
    output logic              jump_en,
    output logic [XLEN-1:0]   jump_addr,
    output logic              retire,
    output logic [1:0]        exc
);
    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned CNTW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;
    state_t state_q, state_d;

    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d, jump_addr_q, jump_addr_d;
    logic [1:0]      exc_q, exc_d;
    logic            wb_we_q, wb_we_d, wb_jump_q, wb_jump_d;

    logic            is_load, is_store, legal, aligned, br_taken, sx;
    logic [XLEN-1:0] ea, shifted, load_val;
    logic [OFFW-1:0] off;
    logic [NB-1:0]   strb_base;

    assign ea       = rs1_q + imm_q;
    assign off      = ea[OFFW-1:0];
    assign is_load  = (opcode_q == OP_LOAD);
    assign is_store = (opcode_q == OP_STORE);
    assign sx       = ~funct3_q[2];
    assign shifted  = mem_rdata >> {off, 3'b000};

    always_comb begin
        legal = 1'b0;
        case (opcode_q)
            OP_LUI, OP_AUIPC, OP_JAL, OP_OP, OP_OPIMM: legal = 1'b1;
            OP_JALR:   legal = (funct3_q == 3'b000);
            OP_BRANCH: legal = (funct3_q[2:1] != 2'b01);
            OP_LOAD: begin
                case (funct3_q)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                    3'b011, 3'b110:                         legal = (XLEN == 64);
                    default:                                legal = 1'b0;
                endcase
            end
            OP_STORE:  legal = ~funct3_q[2] & ((funct3_q[1:0] != 2'b11) | (XLEN == 64));
            default:   legal = 1'b0;
        endcase
    end

    always_comb begin
        aligned   = 1'b1;
        strb_base = NB'(1);
        load_val  = shifted;
        case (funct3_q[1:0])
            2'd0: begin
                strb_base = NB'(1);
                load_val  = sx ? XLEN'($signed(shifted[7:0])) : XLEN'(shifted[7:0]);
            end
            2'd1: begin
                aligned   = ~ea[0];
                strb_base = NB'(3);
                load_val  = sx ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
            end
            2'd2: begin
                aligned   = (ea[1:0] == 2'b00);
                strb_base = NB'(15);
                load_val  = sx ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
            end
            default: begin
                aligned   = (ea[2:0] == 3'b000);
                strb_base = NB'(255);
                load_val  = shifted;
            end
        endcase
    end

    always_comb begin
        case (funct3_q)
            3'b000:  br_taken = (rs1_q == rs2_q);
            3'b001:  br_taken = (rs1_q != rs2_q);
            3'b100:  br_taken = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  br_taken = (rs1_q <  rs2_q);
            default: br_taken = (rs1_q >= rs2_q);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_data_d   = rd_data_q;
        jump_addr_d = jump_addr_q;
        exc_d       = exc_q;
        wb_we_d     = wb_we_q;
        wb_jump_d   = wb_jump_q;
        case (state_q)
            S_IDLE: if (instr_valid) state_d = S_EXEC;
            S_EXEC: begin
                state_d     = S_WB;
                cnt_d       = '0;
                rd_data_d   = '0;
                jump_addr_d = '0;
                exc_d       = 2'b00;
                wb_we_d     = 1'b0;
                wb_jump_d   = 1'b0;
                if (!legal) begin
                    exc_d = 2'b11;
                end else if (is_load || is_store) begin
                    if (aligned) state_d = S_MEM;
                    else         exc_d   = 2'b01;
                end else begin
                    case (opcode_q)
                        OP_LUI: begin
                            rd_data_d = imm_q;
                            wb_we_d   = 1'b1;
                        end
                        OP_AUIPC: begin
                            rd_data_d = pc_q + imm_q;
                            wb_we_d   = 1'b1;
                        end
                        OP_JAL, OP_JALR: begin
                            rd_data_d   = pc_q + XLEN'(PC_STEP);
                            jump_addr_d = (opcode_q == OP_JAL) ? pc_q + imm_q
                                                               : ea & ~XLEN'(1);
                            wb_we_d     = 1'b1;
                            wb_jump_d   = 1'b1;
                        end
                        OP_BRANCH: begin
                            jump_addr_d = pc_q + imm_q;
                            wb_jump_d   = br_taken;
                        end
                        default: begin
                            rd_data_d = alu_result;
                            wb_we_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_MEM: begin
                cnt_d = cnt_q + 1'b1;
                // An ack in the final permitted cycle still completes normally.
                if (mem_ack) begin
                    state_d = S_WB;
                    if (is_load) begin
                        rd_data_d = load_val;
                        wb_we_d   = 1'b1;
                    end
                end else if (cnt_q == CNTW'(MEM_TIMEOUT - 1)) begin
                    state_d = S_WB;
                    exc_d   = 2'b10;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_data_q   <= '0;
            jump_addr_q <= '0;
            exc_q       <= '0;
            wb_we_q     <= 1'b0;
            wb_jump_q   <= 1'b0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= rd_data_d;
            jump_addr_q <= jump_addr_d;
            exc_q       <= exc_d;
            wb_we_q     <= wb_we_d;
            wb_jump_q   <= wb_jump_d;
            if (state_q == S_IDLE && instr_valid) begin
                opcode_q <= opcode;
                funct3_q <= funct3;
                rs1_q    <= rs1_val;
                rs2_q    <= rs2_val;
                imm_q    <= imm;
                pc_q     <= pc;
            end
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign mem_req     = (state_q == S_MEM);
    assign mem_we      = mem_req & is_store;
    assign mem_addr    = mem_req ? {ea[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
    assign mem_wdata   = mem_we ? (rs2_q << {off, 3'b000}) : '0;
    assign mem_wstrb   = mem_we ? (strb_base << off) : '0;
    assign retire      = (state_q == S_WB);
    assign rd_we       = retire & wb_we_q;
    assign jump_en     = retire & wb_jump_q;
    assign rd_data     = rd_data_q;
    assign jump_addr   = jump_addr_q;
    assign exc         = retire ? exc_q : 2'b00;

endmodule

// File: tb/tb_riscv_exec_ctrl.sv
// Bench for riscv_exec_ctrl (XLEN=32): directed cases plus random instructions
// compared against a byte-level reference model of the instruction semantics.
module tb_riscv_exec_ctrl;
    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val, imm, pc, alu_result, mem_rdata;
    logic        mem_ack, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] rd_data, jump_addr;
    logic        rd_we, jump_en, retire;
    logic [1:0]  exc;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] last_rd, last_ja, last_addr, last_wd;
    logic [3:0]  last_strb;
    logic        last_jmp, last_we;
    logic [1:0]  last_exc;

    riscv_exec_ctrl #(.XLEN(32), .PC_STEP(1), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .imm(imm), .pc(pc), .alu_result(alu_result), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .rd_data(rd_data), .rd_we(rd_we),
        .jump_en(jump_en), .jump_addr(jump_addr), .retire(retire), .exc(exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mem;
        bit          st;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdm;
        bit          rdwe;
        logic [31:0] rd;
        bit          jmp;
        logic [31:0] ja;
        logic [1:0]  exc;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] bytemask(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic exp_t ref_model(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] im, input logic [31:0] p,
                                       input logic [31:0] alu, input logic [31:0] rdata);
        exp_t        e;
        logic [31:0] ea, val, mask;
        int unsigned off, nb;
        bit          tk;
        e = '{default: 0};
        ea  = a + im;
        off = ea % 4;
        nb  = 1 << f3[1:0];
        tk  = 0;
        case (op)
            7'h33, 7'h13: begin e.rdwe = 1; e.rd = alu; end
            7'h37: begin e.rdwe = 1; e.rd = im; end
            7'h17: begin e.rdwe = 1; e.rd = p + im; end
            7'h6F: begin e.rdwe = 1; e.rd = p + 1; e.jmp = 1; e.ja = p + im; end
            7'h67: begin
                if (f3 == 0) begin e.rdwe = 1; e.rd = p + 1; e.jmp = 1; e.ja = {ea[31:1], 1'b0}; end
                else e.exc = 2'b11;
            end
            7'h63: begin
                case (f3)
                    0: tk = (a == b);
                    1: tk = (a != b);
                    4: tk = (int'(a) <  int'(b));
                    5: tk = (int'(a) >= int'(b));
                    6: tk = (longint'(a) <  longint'(b));
                    7: tk = (longint'(a) >= longint'(b));
                    default: e.exc = 2'b11;
                endcase
                if (tk) begin e.jmp = 1; e.ja = p + im; end
            end
            7'h03: begin
                if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e.exc = 2'b11;
                else if (ea % nb != 0) e.exc = 2'b01;
                else begin
                    e.mem  = 1;
                    e.addr = ea - off;
                    mask   = 32'((64'd1 << (8 * nb)) - 1);
                    val    = (rdata >> (8 * off)) & mask;
                    if (!f3[2] && val[8*nb-1]) val = val | ~mask;
                    e.rdwe = 1;
                    e.rd   = val;
                end
            end
            7'h23: begin
                if (f3 > 2) e.exc = 2'b11;
                else if (ea % nb != 0) e.exc = 2'b01;
                else begin
                    e.mem  = 1;
                    e.st   = 1;
                    e.addr = ea - off;
                    e.strb = 4'(((1 << nb) - 1) << off);
                    for (int unsigned i = 0; i < nb; i++) e.wdm[8*(off+i) +: 8] = b[8*i +: 8];
                end
            end
            default: e.exc = 2'b11;
        endcase
        return e;
    endfunction

    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                             input logic [31:0] p, input logic [31:0] alu, input logic [31:0] rdata,
                             input int unsigned ackd);
        exp_t        e;
        int unsigned t, reqc, lat_exp, req_exp;
        bit          done, tmo;
        e   = ref_model(op, f3, a, b, im, p, alu, rdata);
        tmo = e.mem && (ackd >= TO);
        if (tmo) begin e.rdwe = 0; e.exc = 2'b10; end
        lat_exp = !e.mem ? 2 : (tmo ? 2 + TO : 3 + ackd);
        req_exp = !e.mem ? 0 : (tmo ? TO : ackd + 1);

        chk({tag, ".ready_idle"}, instr_ready, 1);
        opcode = op; funct3 = f3; rs1_val = a; rs2_val = b; imm = im; pc = p;
        alu_result = alu; mem_rdata = rdata; instr_valid = 1'b1; mem_ack = 1'b0;
        t = 0; reqc = 0; done = 0;
        last_addr = '0; last_strb = '0; last_wd = '0;
        while (!done && t < 60) begin
            @(negedge clk);
            t++;
            if (t == 1) begin
                chk({tag, ".busy"}, instr_ready, 0);
                // Operands must have been captured; the held instr_valid must be ignored.
                opcode = 7'h33; funct3 = ~f3; rs1_val = ~a; rs2_val = ~b; imm = ~im; pc = ~p;
            end
            if (retire) begin
                done = 1;
            end else if (mem_req) begin
                chk({tag, ".addr"}, mem_addr, e.addr);
                chk({tag, ".we"}, mem_we, e.st);
                chk({tag, ".wstrb"}, mem_wstrb, e.strb);
                chk({tag, ".wdata"}, mem_wdata & bytemask(e.strb), e.wdm);
                last_addr = mem_addr; last_strb = mem_wstrb; last_wd = mem_wdata;
                mem_ack = (reqc == ackd);
                reqc++;
            end else begin
                mem_ack = 1'b0;
            end
        end
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        chk({tag, ".retired"}, done, 1);
        chk({tag, ".latency"}, t, lat_exp);
        chk({tag, ".req_cycles"}, reqc, req_exp);
        chk({tag, ".exc"}, exc, e.exc);
        chk({tag, ".rd_we"}, rd_we, e.rdwe);
        chk({tag, ".jump_en"}, jump_en, e.jmp);
        if (e.rdwe) chk({tag, ".rd_data"}, rd_data, e.rd);
        if (e.jmp)  chk({tag, ".jump_addr"}, jump_addr, e.ja);
        last_rd = rd_data; last_ja = jump_addr; last_jmp = jump_en;
        last_we = rd_we; last_exc = exc;
        @(negedge clk);
        chk({tag, ".ready_after"}, instr_ready, 1);
        chk({tag, ".single_retire"}, retire, 0);
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; opcode = '0; funct3 = '0; rs1_val = '0; rs2_val = '0;
        imm = '0; pc = '0; alu_result = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.ready", instr_ready, 1);
        chk("rst.mem_req", mem_req, 0);
        chk("rst.mem_we", mem_we, 0);
        chk("rst.wstrb", mem_wstrb, 0);
        chk("rst.rd_we", rd_we, 0);
        chk("rst.retire", retire, 0);
        chk("rst.jump_en", jump_en, 0);
        chk("rst.rd_data", rd_data, 0);
        chk("rst.exc", exc, 0);
        rst = 1'b0;
        @(negedge clk);

        run_instr("addi", 7'h13, 3'd0, 32'h1, 32'h0, 32'h4, 32'h0, 32'h5, 32'h0, 0);
        chk("addi.rd_const", last_rd, 32'h5);
        chk("addi.we_const", last_we, 1);

        run_instr("blt", 7'h63, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h10, 32'h40, 32'h0, 32'h0, 0);
        chk("blt.taken", last_jmp, 1);
        chk("blt.target", last_ja, 32'h50);
        run_instr("bltu", 7'h63, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h10, 32'h40, 32'h0, 32'h0, 0);
        chk("bltu.not_taken", last_jmp, 0);

        run_instr("sb", 7'h23, 3'd0, 32'h100, 32'h1234_56F0, 32'h3, 32'h0, 32'h0, 32'h0, 0);
        chk("sb.strb_const", last_strb, 4'b1000);
        chk("sb.addr_const", last_addr, 32'h100);
        chk("sb.lane_const", last_wd[31:24], 8'hF0);
        run_instr("lb", 7'h03, 3'd0, 32'h100, 32'h0, 32'h3, 32'h0, 32'h0, 32'hF000_0000, 0);
        chk("lb.rd_const", last_rd, 32'hFFFF_FFF0);
        run_instr("lbu", 7'h03, 3'd4, 32'h100, 32'h0, 32'h3, 32'h0, 32'h0, 32'hF000_0000, 0);
        chk("lbu.rd_const", last_rd, 32'h0000_00F0);

        run_instr("lw_mis", 7'h03, 3'd2, 32'h100, 32'h0, 32'h2, 32'h0, 32'h0, 32'h0, 0);
        chk("lw_mis.exc_const", last_exc, 2'b01);
        run_instr("lw_wait3", 7'h03, 3'd2, 32'h200, 32'h0, 32'h4, 32'h0, 32'h0, 32'hCAFE_0001, 3);
        run_instr("lw_edge", 7'h03, 3'd2, 32'h200, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0BAD_F00D, TO - 1);
        chk("lw_edge.exc_const", last_exc, 2'b00);
        run_instr("lw_tmo", 7'h03, 3'd2, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 100);
        chk("lw_tmo.exc_const", last_exc, 2'b10);
        run_instr("ld_ill", 7'h03, 3'd3, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        chk("ld_ill.exc_const", last_exc, 2'b11);
        run_instr("jalr", 7'h67, 3'd0, 32'h1001, 32'h0, 32'h4, 32'h20, 32'h0, 32'h0, 0);
        chk("jalr.target_const", last_ja, 32'h1004);
        chk("jalr.link_const", last_rd, 32'h21);

        // Reset in the middle of a memory wait abandons the load.
        opcode = 7'h03; funct3 = 3'd2; rs1_val = 32'h300; imm = 32'h0; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("rstmem.req_seen", mem_req, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmem.req_drop", mem_req, 0);
        chk("rstmem.ready", instr_ready, 1);
        chk("rstmem.retire", retire, 0);
        chk("rstmem.rd_we", rd_we, 0);
        rst = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rstmem.late_ack_retire", retire, 0);
        chk("rstmem.late_ack_rd_we", rd_we, 0);
        chk("rstmem.late_ack_req", mem_req, 0);
        @(negedge clk);
        chk("rstmem.idle_retire", retire, 0);
        run_instr("after_rst", 7'h37, 3'd0, 32'h0, 32'h0, 32'hABCD_E000, 32'h0, 32'h0, 32'h0, 0);

        for (int k = 0; k < 80; k++) begin
            logic [6:0]  op;
            logic [2:0]  f3;
            logic [31:0] a, b;
            int unsigned sel, ackd;
            sel = $urandom_range(0, 9);
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            case (sel)
                0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h37;  3: op = 7'h17;
                4: op = 7'h6F;  5: op = 7'h67;  6: op = 7'h63;  7: op = 7'h03;
                8: op = 7'h23;  default: op = 7'h0B;
            endcase
            if (sel == 5 && $urandom_range(0, 3) != 0) f3 = 3'd0;
            ackd = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 4);
            run_instr($sformatf("rand%0d", k), op, f3, a, b, 32'($urandom_range(0, 255)) - 32'd64,
                      $urandom, $urandom, $urandom, ackd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
